// File: rtl/qcw_wb_pkg.sv
// Shared register map, STATUS bit positions and response codes for the QCW burst master.
package qcw_wb_pkg;

  localparam logic [31:0] OFS_PHASE_START = 32'h00;
  localparam logic [31:0] OFS_PHASE_STEP  = 32'h04;
  localparam logic [31:0] OFS_CYCLE_LIMIT = 32'h08;
  localparam logic [31:0] OFS_CONTROL     = 32'h0C;
  localparam logic [31:0] OFS_STATUS      = 32'h10;
  localparam logic [31:0] OFS_CURRENT     = 32'h14;

  localparam int unsigned STAT_DONE_BIT  = 0;
  localparam int unsigned STAT_FAULT_BIT = 1;

  localparam logic [2:0] RSP_OK         = 3'd0;
  localparam logic [2:0] RSP_FAULT      = 3'd1;
  localparam logic [2:0] RSP_BUS_TMO    = 3'd2;
  localparam logic [2:0] RSP_POLL_TMO   = 3'd3;
  localparam logic [2:0] RSP_VERIFY_ERR = 3'd4;

  typedef enum logic {PH_ARM, PH_DONE} poll_phase_e;

endpackage

// File: rtl/wb_master_xact.sv
// Single Wishbone transaction engine: ack timeout and post-cycle idle gap live here.
module wb_master_xact #(
  parameter int unsigned ACK_TIMEOUT = 255
)(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] adr,
  input  logic [31:0] wdat,
  output logic        done,
  output logic        timeout,
  output logic [31:0] rdat,
  output logic [31:0] wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  output logic [3:0]  wbm_sel_o,
  output logic        wbm_we_o,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  input  logic        wbm_ack_i,
  input  logic [31:0] wbm_dat_i
);

  typedef enum logic [1:0] {X_IDLE, X_BUS, X_GAP} xact_state_e;

  xact_state_e x_state, x_next;
  logic [31:0] ack_cnt;
  logic        cyc_q, we_q;
  logic [31:0] adr_q, dat_q;
  logic        tmo_hit;

  // Ack takes priority over the timeout on the same clock.
  assign tmo_hit = (ack_cnt == 32'(ACK_TIMEOUT - 1));

  always_comb begin
    x_next = x_state;
    unique case (x_state)
      X_IDLE:  if (req) x_next = X_BUS;
      X_BUS:   if (wbm_ack_i || tmo_hit) x_next = X_GAP;
      X_GAP:   x_next = X_IDLE;
      default: x_next = X_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_state <= X_IDLE;
      ack_cnt <= '0;
      cyc_q   <= 1'b0;
      we_q    <= 1'b0;
      adr_q   <= '0;
      dat_q   <= '0;
      done    <= 1'b0;
      timeout <= 1'b0;
      rdat    <= '0;
    end else begin
      x_state <= x_next;
      cyc_q   <= (x_next == X_BUS);
      done    <= (x_state == X_BUS) && wbm_ack_i;
      timeout <= (x_state == X_BUS) && !wbm_ack_i && tmo_hit;
      ack_cnt <= (x_state == X_BUS) ? ack_cnt + 32'd1 : '0;
      if (x_state == X_IDLE && req) begin
        adr_q <= adr;
        dat_q <= wdat;
        we_q  <= we;
      end
      if (x_state == X_BUS && wbm_ack_i) rdat <= wbm_dat_i;
    end
  end

  assign wbm_cyc_o = cyc_q;
  assign wbm_stb_o = cyc_q;
  assign wbm_we_o  = cyc_q & we_q;
  assign wbm_sel_o = cyc_q ? 4'hF : 4'h0;
  assign wbm_adr_o = adr_q;
  assign wbm_dat_o = dat_q;

endmodule

// File: rtl/wb_qcw_burst_master.sv
// Programs the QCW config registers, fires START once and polls STATUS to a result code.
// Build option WB_QCW_READBACK_EN adds a readback verify after each config write.
module wb_qcw_burst_master
  import qcw_wb_pkg::*;
#(
  parameter logic [31:0] TARGET_ADR    = 32'h1000000,
  parameter int unsigned POLL_INTERVAL = 1024,
  parameter int unsigned ACK_TIMEOUT   = 255,
  parameter int unsigned POLL_LIMIT    = 65535
)(
  input  logic        wb_clk_i,
  input  logic        wb_rst_n_i,
  output logic [31:0] wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  output logic [3:0]  wbm_sel_o,
  output logic        wbm_we_o,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  input  logic        wbm_ack_i,
  input  logic [31:0] wbm_dat_i,
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  input  logic [7:0]  cmd_phase_start_i,
  input  logic [15:0] cmd_phase_step_i,
  input  logic [15:0] cmd_cycle_limit_i,
  output logic        rsp_valid_o,
  output logic [2:0]  rsp_status_o,
  output logic [15:0] rsp_polls_o,
  output logic        busy_o
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_WR_PSTART,
`ifdef WB_QCW_READBACK_EN
    S_RB_PSTART,
    S_RB_PSTEP,
    S_RB_CLIM,
`endif
    S_WR_PSTEP,
    S_WR_CLIM,
    S_WR_START,
    S_WAIT,
    S_RD_STAT,
    S_EVAL,
    S_RESP
  } state_e;

  state_e      state, next;
  logic [7:0]  ps_q;
  logic [15:0] step_q, lim_q;
  logic [1:0]  stat_q;
  poll_phase_e phase_q;
  logic [31:0] arm_cnt, done_cnt, wait_cnt;
  logic [2:0]  rsp_status_q;
  logic [15:0] rsp_polls_q;

  logic        x_req, x_we, x_done, x_timeout;
  logic [31:0] x_adr, x_wdat, x_rdat;
  logic        set_rsp, enter_done_phase;
  logic [2:0]  rsp_code;
  logic        accept;

  assign accept = (state == S_IDLE) && cmd_valid_i;

  wb_master_xact #(.ACK_TIMEOUT(ACK_TIMEOUT)) u_xact (
    .clk       (wb_clk_i),
    .rst_n     (wb_rst_n_i),
    .req       (x_req),
    .we        (x_we),
    .adr       (x_adr),
    .wdat      (x_wdat),
    .done      (x_done),
    .timeout   (x_timeout),
    .rdat      (x_rdat),
    .wbm_adr_o (wbm_adr_o),
    .wbm_dat_o (wbm_dat_o),
    .wbm_sel_o (wbm_sel_o),
    .wbm_we_o  (wbm_we_o),
    .wbm_cyc_o (wbm_cyc_o),
    .wbm_stb_o (wbm_stb_o),
    .wbm_ack_i (wbm_ack_i),
    .wbm_dat_i (wbm_dat_i)
  );

`ifdef WB_QCW_READBACK_EN
  logic [15:0] rdat_unused;
  assign rdat_unused = x_rdat[31:16];
`else
  logic [29:0] rdat_unused;
  assign rdat_unused = x_rdat[31:2];
`endif

  always_comb begin
    next             = state;
    x_req            = 1'b0;
    x_we             = 1'b0;
    x_adr            = TARGET_ADR;
    x_wdat           = '0;
    set_rsp          = 1'b0;
    rsp_code         = RSP_OK;
    enter_done_phase = 1'b0;
    unique case (state)
      S_IDLE: if (cmd_valid_i) next = S_WR_PSTART;
      S_WR_PSTART: begin
        x_req  = 1'b1;
        x_we   = 1'b1;
        x_adr  = TARGET_ADR + OFS_PHASE_START;
        x_wdat = {24'h0, ps_q};
        if (x_done) begin
`ifdef WB_QCW_READBACK_EN
          next = S_RB_PSTART;
`else
          next = S_WR_PSTEP;
`endif
        end
      end
`ifdef WB_QCW_READBACK_EN
      S_RB_PSTART: begin
        x_req = 1'b1;
        x_adr = TARGET_ADR + OFS_PHASE_START;
        if (x_done) begin
          if (x_rdat[7:0] != ps_q) begin
            next = S_RESP; set_rsp = 1'b1; rsp_code = RSP_VERIFY_ERR;
          end else next = S_WR_PSTEP;
        end
      end
      S_RB_PSTEP: begin
        x_req = 1'b1;
        x_adr = TARGET_ADR + OFS_PHASE_STEP;
        if (x_done) begin
          if (x_rdat[15:0] != step_q) begin
            next = S_RESP; set_rsp = 1'b1; rsp_code = RSP_VERIFY_ERR;
          end else next = S_WR_CLIM;
        end
      end
      S_RB_CLIM: begin
        x_req = 1'b1;
        x_adr = TARGET_ADR + OFS_CYCLE_LIMIT;
        if (x_done) begin
          if (x_rdat[15:0] != lim_q) begin
            next = S_RESP; set_rsp = 1'b1; rsp_code = RSP_VERIFY_ERR;
          end else next = S_WR_START;
        end
      end
`endif
      S_WR_PSTEP: begin
        x_req  = 1'b1;
        x_we   = 1'b1;
        x_adr  = TARGET_ADR + OFS_PHASE_STEP;
        x_wdat = {16'h0, step_q};
        if (x_done) begin
`ifdef WB_QCW_READBACK_EN
          next = S_RB_PSTEP;
`else
          next = S_WR_CLIM;
`endif
        end
      end
      S_WR_CLIM: begin
        x_req  = 1'b1;
        x_we   = 1'b1;
        x_adr  = TARGET_ADR + OFS_CYCLE_LIMIT;
        x_wdat = {16'h0, lim_q};
        if (x_done) begin
`ifdef WB_QCW_READBACK_EN
          next = S_RB_CLIM;
`else
          next = S_WR_START;
`endif
        end
      end
      S_WR_START: begin
        x_req  = 1'b1;
        x_we   = 1'b1;
        x_adr  = TARGET_ADR + OFS_CONTROL;
        x_wdat = 32'd1;
        if (x_done) next = S_WAIT;
      end
      S_WAIT: if (wait_cnt == 32'(POLL_INTERVAL - 1)) next = S_RD_STAT;
      S_RD_STAT: begin
        x_req = 1'b1;
        x_adr = TARGET_ADR + OFS_STATUS;
        if (x_done) next = S_EVAL;
      end
      S_EVAL: begin
        next = S_WAIT;
        if (stat_q[STAT_FAULT_BIT]) begin
          next = S_RESP; set_rsp = 1'b1; rsp_code = RSP_FAULT;
        end else if (phase_q == PH_ARM) begin
          if (!stat_q[STAT_DONE_BIT]) enter_done_phase = 1'b1;
          else if (arm_cnt == 32'(POLL_LIMIT)) begin
            next = S_RESP; set_rsp = 1'b1; rsp_code = RSP_POLL_TMO;
          end
        end else if (stat_q[STAT_DONE_BIT]) begin
          next = S_RESP; set_rsp = 1'b1; rsp_code = RSP_OK;
        end else if (done_cnt == 32'(POLL_LIMIT)) begin
          next = S_RESP; set_rsp = 1'b1; rsp_code = RSP_POLL_TMO;
        end
      end
      S_RESP:  next = S_IDLE;
      default: next = S_IDLE;
    endcase
    // The engine only pulses timeout in the clock after a cycle this state issued.
    if (x_timeout) begin
      next = S_RESP; set_rsp = 1'b1; rsp_code = RSP_BUS_TMO;
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      state        <= S_IDLE;
      ps_q         <= '0;
      step_q       <= '0;
      lim_q        <= '0;
      stat_q       <= '0;
      phase_q      <= PH_ARM;
      arm_cnt      <= '0;
      done_cnt     <= '0;
      wait_cnt     <= '0;
      rsp_status_q <= '0;
      rsp_polls_q  <= '0;
    end else begin
      state    <= next;
      wait_cnt <= (state == S_WAIT) ? wait_cnt + 32'd1 : '0;
      if (accept) begin
        ps_q     <= cmd_phase_start_i;
        step_q   <= cmd_phase_step_i;
        lim_q    <= cmd_cycle_limit_i;
        phase_q  <= PH_ARM;
        arm_cnt  <= '0;
        done_cnt <= '0;
      end
      if (state == S_RD_STAT && x_done) begin
        stat_q <= x_rdat[1:0];
        if (phase_q == PH_ARM) arm_cnt <= arm_cnt + 32'd1;
        else                   done_cnt <= done_cnt + 32'd1;
      end
      if (enter_done_phase) phase_q <= PH_DONE;
      if (set_rsp) begin
        rsp_status_q <= rsp_code;
        rsp_polls_q  <= (done_cnt > 32'h0000_FFFF) ? 16'hFFFF : done_cnt[15:0];
      end
    end
  end

  assign cmd_ready_o  = (state == S_IDLE);
  assign busy_o       = (state != S_IDLE);
  assign rsp_valid_o  = (state == S_RESP);
  assign rsp_status_o = rsp_status_q;
  assign rsp_polls_o  = rsp_polls_q;

endmodule

// File: tb/tb_wb_qcw_burst_master.sv
// Scoreboard bench for wb_qcw_burst_master with a behavioural Wishbone responder.
module tb_wb_qcw_burst_master;

  localparam logic [31:0] TGT = 32'h0002_0000;
  localparam int unsigned PI  = 3;
  localparam int unsigned AT  = 4;
  localparam int unsigned PL  = 5;
  localparam logic [31:0] NONE = 32'hFFFF_FFFF;

  logic        clk, rst_n;
  logic [31:0] adr, dat_o, dat_i;
  logic [3:0]  sel;
  logic        we, cyc, stb, ack;
  logic        cmd_valid, cmd_ready, rsp_valid, busy;
  logic [7:0]  ps;
  logic [15:0] step, lim, rsp_polls;
  logic [2:0]  rsp_status;

  wb_qcw_burst_master #(
    .TARGET_ADR(TGT), .POLL_INTERVAL(PI), .ACK_TIMEOUT(AT), .POLL_LIMIT(PL)
  ) dut (
    .wb_clk_i(clk), .wb_rst_n_i(rst_n),
    .wbm_adr_o(adr), .wbm_dat_o(dat_o), .wbm_sel_o(sel), .wbm_we_o(we),
    .wbm_cyc_o(cyc), .wbm_stb_o(stb), .wbm_ack_i(ack), .wbm_dat_i(dat_i),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready),
    .cmd_phase_start_i(ps), .cmd_phase_step_i(step), .cmd_cycle_limit_i(lim),
    .rsp_valid_o(rsp_valid), .rsp_status_o(rsp_status), .rsp_polls_o(rsp_polls),
    .busy_o(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { logic we; logic [31:0] adr; logic [31:0] dat; } xact_t;
  typedef struct { logic [2:0] st; logic [15:0] polls; } rsp_t;
  xact_t exp_x[$];
  rsp_t  exp_r[$];
  int n_pass = 0, n_chk = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s: actual %0h required %0h at %0t", name, act, req, $time);
  endtask

  // Responder scenario, set by the stimulus only while the DUT is idle.
  int          lat;
  logic [31:0] noack_off;
  bit          corrupt;
  logic [31:0] st_arr[0:15];
  int          st_len;

  function automatic logic [31:0] st_word(input int i);
    return (i < st_len) ? st_arr[i] : st_arr[st_len-1];
  endfunction

  // Responder: acks after lat extra clocks and holds ack while stb is high.
  logic [31:0] regs[0:7];
  int st_idx, wcnt;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack  <= 1'b0;
      wcnt <= 0;
    end else if (cyc && stb && !ack) begin
      if ((adr - TGT) != noack_off) begin
        if (wcnt >= lat) begin
          ack  <= 1'b1;
          wcnt <= 0;
          if (we) begin
            regs[adr[4:2]] <= dat_o;
            if ((adr - TGT) == 32'd12) st_idx <= 0;
          end else if ((adr - TGT) == 32'd16) begin
            dat_i  <= st_word(st_idx);
            st_idx <= st_idx + 1;
          end else if ((adr - TGT) == 32'd0 && corrupt) dat_i <= regs[0] ^ 32'd1;
          else dat_i <= regs[adr[4:2]];
        end else wcnt <= wcnt + 1;
      end
    end else if (!stb) begin
      ack  <= 1'b0;
      wcnt <= 0;
    end
  end

  // Monitor: pops expectations whenever the DUT completes a cycle or responds.
  logic prev_stb, prev_cyc, acked, after_rsp;
  int   run, idle_run, rsp_count = 0;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stb <= 1'b0; prev_cyc <= 1'b0; acked <= 1'b0; after_rsp <= 1'b0;
      run <= 0; idle_run <= 1;
    end else begin
      if (cyc && stb && ack) begin
        if (exp_x.size() == 0) begin
          n_chk++;
          $display("FAIL xact_unexpected: actual we=%0b adr=%0h required none", we, adr);
        end else begin
          xact_t e;
          e = exp_x.pop_front();
          chk("xact_we", {31'b0, we}, {31'b0, e.we});
          chk("xact_adr", adr, e.adr);
          chk("xact_sel", {28'b0, sel}, 32'hF);
          if (e.we) chk("xact_wdat", dat_o, e.dat);
        end
      end
      if (stb) begin
        if (!prev_stb) begin run <= 1; acked <= ack; end
        else begin run <= run + 1; acked <= acked | ack; end
      end else if (prev_stb && !acked) chk("ack_timeout_len", run, AT);
      if (cyc && !prev_cyc) chk("idle_gap", {31'b0, idle_run != 0}, 32'd1);
      idle_run <= cyc ? 0 : idle_run + 1;
      if (after_rsp) begin
        chk("busy_after_rsp", {31'b0, busy}, 32'd0);
        chk("ready_after_rsp", {31'b0, cmd_ready}, 32'd1);
        chk("rsp_one_clock", {31'b0, rsp_valid}, 32'd0);
      end
      after_rsp <= rsp_valid;
      if (rsp_valid) begin
        rsp_count <= rsp_count + 1;
        if (exp_r.size() == 0) begin
          n_chk++;
          $display("FAIL rsp_unexpected: actual status=%0d polls=%0d required none", rsp_status, rsp_polls);
        end else begin
          rsp_t r;
          r = exp_r.pop_front();
          chk("rsp_status", {29'b0, rsp_status}, {29'b0, r.st});
          chk("rsp_polls", {16'b0, rsp_polls}, {16'b0, r.polls});
        end
      end
      prev_stb <= stb;
      prev_cyc <= cyc;
    end
  end

  // Reference model: the list of acked bus cycles and the final response.
  task automatic add(input logic w, input logic [31:0] off, input logic [31:0] d, output bit ok);
    ok = (off != noack_off);
    if (ok) exp_x.push_back('{w, TGT + off, d});
  endtask

  task automatic model(input logic [7:0] p, input logic [15:0] s, input logic [15:0] l);
    bit ok, in_done;
    int arm, dn;
    logic [31:0] w;
    in_done = 0; arm = 0; dn = 0;
    add(1, 0, {24'b0, p}, ok);
    if (!ok) begin exp_r.push_back('{3'd2, 16'd0}); return; end
`ifdef WB_QCW_READBACK_EN
    add(0, 0, 0, ok);
    if (!ok) begin exp_r.push_back('{3'd2, 16'd0}); return; end
    if (corrupt) begin exp_r.push_back('{3'd4, 16'd0}); return; end
`endif
    add(1, 4, {16'b0, s}, ok);
    if (!ok) begin exp_r.push_back('{3'd2, 16'd0}); return; end
`ifdef WB_QCW_READBACK_EN
    add(0, 4, 0, ok);
    if (!ok) begin exp_r.push_back('{3'd2, 16'd0}); return; end
`endif
    add(1, 8, {16'b0, l}, ok);
    if (!ok) begin exp_r.push_back('{3'd2, 16'd0}); return; end
`ifdef WB_QCW_READBACK_EN
    add(0, 8, 0, ok);
    if (!ok) begin exp_r.push_back('{3'd2, 16'd0}); return; end
`endif
    add(1, 12, 32'd1, ok);
    if (!ok) begin exp_r.push_back('{3'd2, 16'd0}); return; end
    for (int k = 0; k < 2 * int'(PL) + 2; k++) begin
      w = st_word(k);
      add(0, 16, 0, ok);
      if (!ok) begin exp_r.push_back('{3'd2, 16'(dn)}); return; end
      if (!in_done) begin
        arm++;
        if (w[1]) begin exp_r.push_back('{3'd1, 16'd0}); return; end
        if (!w[0]) in_done = 1;
        else if (arm == int'(PL)) begin exp_r.push_back('{3'd3, 16'd0}); return; end
      end else begin
        dn++;
        if (w[1]) begin exp_r.push_back('{3'd1, 16'(dn)}); return; end
        if (w[0]) begin exp_r.push_back('{3'd0, 16'(dn)}); return; end
        if (dn == int'(PL)) begin exp_r.push_back('{3'd3, 16'(dn)}); return; end
      end
    end
  endtask

  task automatic issue(input logic [7:0] p, input logic [15:0] s, input logic [15:0] l);
    @(negedge clk);
    ps = p; step = s; lim = l; cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    ps = 8'($urandom); step = 16'($urandom); lim = 16'($urandom);
  endtask

  task automatic hard_reset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    exp_x.delete(); exp_r.delete();
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
  endtask

  task automatic run_test(input logic [7:0] p, input logic [15:0] s, input logic [15:0] l);
    int start;
    bit got;
    model(p, s, l);
    start = rsp_count;
    issue(p, s, l);
    got = 0;
    for (int c = 0; c < 3000 && !got; c++) begin
      @(negedge clk);
      if (rsp_count != start) got = 1;
      else if (busy && !rsp_valid && $urandom_range(0, 15) == 0) begin
        cmd_valid = 1'b1; ps = 8'($urandom); step = 16'($urandom); lim = 16'($urandom);
        @(negedge clk);
        cmd_valid = 1'b0;
      end
    end
    if (!got) begin
      n_chk++;
      $display("FAIL rsp_wait: actual no response required one within 3000 clocks");
      hard_reset();
    end
    repeat (10) @(negedge clk);
    chk("xact_left", exp_x.size(), 0);
    chk("rsp_left", exp_r.size(), 0);
  endtask

  task automatic set_st(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c,
                        input logic [31:0] d, input int n);
    st_arr[0] = a; st_arr[1] = b; st_arr[2] = c; st_arr[3] = d; st_len = n;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: actual running required finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int start, kind;
    rst_n = 1'b0; cmd_valid = 1'b0; ps = '0; step = '0; lim = '0; dat_i = '0;
    lat = 0; noack_off = NONE; corrupt = 0; st_idx = 0;
    set_st(1, 1, 1, 1, 1);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_cyc", {31'b0, cyc}, 0);
    chk("rst_stb", {31'b0, stb}, 0);
    chk("rst_we", {31'b0, we}, 0);
    chk("rst_adr", adr, 0);
    chk("rst_sel", {28'b0, sel}, 0);
    chk("rst_ready", {31'b0, cmd_ready}, 1);
    chk("rst_busy", {31'b0, busy}, 0);
    chk("rst_rsp_valid", {31'b0, rsp_valid}, 0);
    chk("rst_rsp_status", {29'b0, rsp_status}, 0);
    chk("rst_rsp_polls", {16'b0, rsp_polls}, 0);

    // Directed: nominal, fault, bus timeout, stale done, late ack, fault+done, zero limit.
    set_st(0, 0, 0, 1, 4);              run_test(8'h10, 16'h0180, 16'd200);
    set_st(2, 2, 2, 2, 1);              run_test(8'h22, 16'h0100, 16'd50);
    noack_off = 8;                      run_test(8'h33, 16'h0200, 16'd10);
    noack_off = NONE;
    set_st(1, 1, 1, 1, 1);              run_test(8'h44, 16'h0080, 16'd7);
    lat = 2; set_st(0, 1, 0, 0, 2);     run_test(8'h55, 16'h0001, 16'd0);
    lat = 3; noack_off = 0;             run_test(8'h66, 16'h0002, 16'd3);
    lat = 0; noack_off = NONE;
    set_st(0, 0, 3, 0, 3);              run_test(8'h77, 16'hFFFF, 16'hFFFF);
    set_st(0, 0, 0, 0, 1);              run_test(8'h88, 16'h1234, 16'd9);
`ifdef WB_QCW_READBACK_EN
    corrupt = 1; set_st(0, 1, 0, 0, 2); run_test(8'h10, 16'h0180, 16'd200);
    corrupt = 0;
`endif

    // Reset while the +4 write is on the bus.
    lat = 2; set_st(0, 1, 0, 0, 2);
    model(8'h99, 16'h0042, 16'd5);
    start = rsp_count;
    issue(8'h99, 16'h0042, 16'd5);
    begin
      bit seen = 0;
      for (int c = 0; c < 200 && !seen; c++) begin
        @(negedge clk);
        if (cyc && stb && adr == TGT + 32'd4) seen = 1;
      end
      chk("rst_mid_seen_pstep", {31'b0, seen}, 1);
    end
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_cyc", {31'b0, cyc}, 0);
    chk("rst_mid_stb", {31'b0, stb}, 0);
    exp_x.delete(); exp_r.delete();
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_mid_ready", {31'b0, cmd_ready}, 1);
    repeat (20) @(negedge clk);
    chk("rst_mid_no_rsp", rsp_count, start);

    // Randomized scenarios.
    for (int t = 0; t < 30; t++) begin
      lat = $urandom_range(0, 2);
      noack_off = NONE;
      corrupt = 0;
`ifdef WB_QCW_READBACK_EN
      corrupt = ($urandom_range(0, 7) == 0);
`endif
      kind = $urandom_range(0, 5);
      if (kind == 3) set_st(1, 1, 1, 1, 1);
      else if (kind == 4) set_st(0, 0, 0, 0, 1);
      else begin
        st_len = $urandom_range(1, 10);
        for (int i = 0; i < st_len; i++)
          st_arr[i] = ($urandom_range(0, 9) == 0) ? 32'd2 | 32'($urandom_range(0, 1))
                                                  : 32'($urandom_range(0, 1));
        if (kind == 5) noack_off = 32'($urandom_range(0, 4)) * 32'd4;
      end
      run_test(8'($urandom), 16'($urandom), ($urandom_range(0, 3) == 0) ? 16'd0 : 16'($urandom));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
